// File: rtl/core_pkg.sv
// Shared front-end types: the instruction-buffer entry and its default sizing.
package core_pkg;

  localparam int IBUF_DEPTH   = 8;
  localparam int IBUF_PC_W    = 32;
  localparam int IBUF_INSTR_W = 32;

  typedef struct packed {
    logic [IBUF_PC_W-1:0]    pc;
    logic [IBUF_INSTR_W-1:0] instr;
  } ibuf_entry_t;

endpackage

// File: rtl/inst_buffer.sv
// Fetch-to-decode decoupling FIFO: compacts up to FETCH_W lanes per cycle,
// presents up to DEC_W oldest entries, stalls fetch early, drops all on flush.
module inst_buffer
  import core_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int DEC_W   = 2,
  parameter int DEPTH   = IBUF_DEPTH,
  parameter int PC_W    = IBUF_PC_W,     // must equal IBUF_PC_W (entry layout)
  parameter int INSTR_W = IBUF_INSTR_W   // must equal IBUF_INSTR_W (entry layout)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [FETCH_W-1:0]                if_valid,
  input  logic [FETCH_W-1:0][PC_W-1:0]      if_pc,
  input  logic [FETCH_W-1:0][INSTR_W-1:0]   if_instr,
  output logic                              fetch_stall,
  output logic [DEC_W-1:0]                  dec_valid,
  output logic [DEC_W-1:0][PC_W-1:0]        dec_pc,
  output logic [DEC_W-1:0][INSTR_W-1:0]     dec_instr,
  input  logic                              dec_ready,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              overflow_err
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int LANE_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_C = CNT_W'(2*FETCH_W);

  function automatic logic [CNT_W-1:0] popcnt_f(input logic [31:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  // Slot j of the result names the fetch lane holding the j-th valid entry.
  function automatic logic [FETCH_W-1:0][LANE_W-1:0] compact_f(input logic [FETCH_W-1:0] v);
    logic [FETCH_W-1:0][LANE_W-1:0] sel;
    int k;
    sel = '0;
    k   = 0;
    for (int i = 0; i < FETCH_W; i++) begin
      if (v[i]) begin
        sel[k] = LANE_W'(i);
        k++;
      end
    end
    return sel;
  endfunction

  ibuf_entry_t mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic [CNT_W-1:0] n_valid, n_enq, n_deq, space;
  logic             drop;
  logic [FETCH_W-1:0][LANE_W-1:0] sel;
  logic [FETCH_W-1:0]             wr_en;
  logic [FETCH_W-1:0][PTR_W-1:0]  wr_idx;
  ibuf_entry_t                    wr_data [FETCH_W];
  logic [DEC_W-1:0][PTR_W-1:0]    rd_idx;

  always_comb begin
    for (int i = 0; i < DEC_W; i++) begin
      dec_valid[i] = (count_q > CNT_W'(i));
      rd_idx[i]    = head_q + PTR_W'(i);
      dec_pc[i]    = mem_q[rd_idx[i]].pc;
      dec_instr[i] = mem_q[rd_idx[i]].instr;
    end
  end

  // Room is judged on the start-of-cycle count; same-cycle dequeues do not help.
  always_comb begin
    n_valid = popcnt_f(32'(if_valid));
    space   = DEPTH_C - count_q;
    drop    = (n_valid > space);
    n_enq   = drop ? space : n_valid;
    n_deq   = dec_ready ? popcnt_f(32'(dec_valid)) : '0;
    sel     = compact_f(if_valid);
    for (int j = 0; j < FETCH_W; j++) begin
      wr_en[j]         = (CNT_W'(j) < n_enq) && !flush && !reset;
      wr_idx[j]        = tail_q + PTR_W'(j);
      wr_data[j].pc    = if_pc[sel[j]];
      wr_data[j].instr = if_instr[sel[j]];
    end
    if (flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      overflow_d = overflow_q;
    end else begin
      head_d     = head_q + PTR_W'(n_deq);
      tail_d     = tail_q + PTR_W'(n_enq);
      count_d    = count_q + n_enq - n_deq;
      overflow_d = overflow_q | drop;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < FETCH_W; j++) begin
      if (wr_en[j]) mem_q[wr_idx[j]] <= wr_data[j];
    end
  end

  assign fetch_stall  = (DEPTH_C - count_q) < STALL_C;
  assign count        = count_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: drivers push expected entries, a negedge
// monitor pops and compares every entry decode consumes.
module tb_inst_buffer;

  logic             clk;
  logic             reset;
  logic             flush;
  logic [1:0]       if_valid;
  logic [1:0][31:0] if_pc;
  logic [1:0][31:0] if_instr;
  logic             fetch_stall;
  logic [1:0]       dec_valid;
  logic [1:0][31:0] dec_pc;
  logic [1:0][31:0] dec_instr;
  logic             dec_ready;
  logic [3:0]       count;
  logic             overflow_err;

  logic [63:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  inst_buffer #(.FETCH_W(2), .DEC_W(2), .DEPTH(8), .PC_W(32), .INSTR_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .fetch_stall(fetch_stall),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_instr(dec_instr),
    .dec_ready(dec_ready), .count(count), .overflow_err(overflow_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one cycle from posedge+1; pushes the first acc valid lanes as expected.
  task automatic cyc(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                     input logic [31:0] in0, input logic [31:0] in1,
                     input logic rdy, input logic fl, input int acc);
    int pushed;
    if_valid    = v;
    if_pc[0]    = pc0;
    if_pc[1]    = pc1;
    if_instr[0] = in0;
    if_instr[1] = in1;
    dec_ready   = rdy;
    flush       = fl;
    pushed      = 0;
    if (fl) exp_q.delete();
    else begin
      if (v[0] && pushed < acc) begin exp_q.push_back({pc0, in0}); pushed++; end
      if (v[1] && pushed < acc) begin exp_q.push_back({pc1, in1}); pushed++; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic grp(input logic [31:0] pc0, input logic rdy, input int acc);
    cyc(2'b11, pc0, pc0 + 32'h4, pc0 ^ 32'hC0DE0000, (pc0 + 32'h4) ^ 32'hC0DE0000, rdy, 1'b0, acc);
  endtask

  task automatic idle(input logic rdy);
    cyc(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, rdy, 1'b0, 0);
  endtask

  // scoreboard monitor: every lane decode consumes must match the queue head
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!reset && !flush && dec_ready) begin
        for (int i = 0; i < 2; i++) begin
          if (dec_valid[i]) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL deq_lane%0d: got pc %0h with nothing expected", i, dec_pc[i]);
            end else begin
              e = exp_q.pop_front();
              if ({dec_pc[i], dec_instr[i]} !== e) begin
                n_fail++;
                $display("FAIL deq_lane%0d: got %0h/%0h expected %0h/%0h",
                         i, dec_pc[i], dec_instr[i], e[63:32], e[31:0]);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; if_valid = '0; if_pc = '0; if_instr = '0; dec_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_stall", 32'(fetch_stall), 32'd0);
    chk("rst_overflow", 32'(overflow_err), 32'd0);

    // fill
    cyc(2'b11, 32'h0, 32'h4, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 2);
    chk("fill_count", 32'(count), 32'd2);
    chk("fill_dec_valid", 32'(dec_valid), 32'h3);
    chk("fill_pc0", dec_pc[0], 32'h0);
    chk("fill_pc1", dec_pc[1], 32'h4);
    chk("fill_instr1", dec_instr[1], 32'h22222222);
    idle(1'b1);
    chk("fill_drained", 32'(count), 32'd0);

    // partial lane
    cyc(2'b10, 32'hDEAD, 32'h14, 32'h0, 32'h33333333, 1'b0, 1'b0, 2);
    chk("part_dec_valid", 32'(dec_valid), 32'h1);
    chk("part_pc0", dec_pc[0], 32'h14);
    chk("part_count", 32'(count), 32'd1);
    idle(1'b1);

    // backpressure and overflow
    grp(32'h20, 1'b0, 2);
    grp(32'h28, 1'b0, 2);
    chk("bp_count4", 32'(count), 32'd4);
    chk("bp_stall4", 32'(fetch_stall), 32'd0);
    grp(32'h30, 1'b0, 2);
    chk("bp_count6", 32'(count), 32'd6);
    chk("bp_stall6", 32'(fetch_stall), 32'd1);
    chk("bp_ovf_pre", 32'(overflow_err), 32'd0);
    grp(32'h38, 1'b0, 2);
    chk("bp_count8", 32'(count), 32'd8);
    grp(32'h40, 1'b0, 0);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_err", 32'(overflow_err), 32'd1);
    repeat (4) idle(1'b1);
    chk("bp_drained", 32'(count), 32'd0);
    chk("bp_stall_clr", 32'(fetch_stall), 32'd0);

    // concurrent enqueue and dequeue
    grp(32'h50, 1'b0, 2);
    grp(32'h58, 1'b0, 2);
    grp(32'h60, 1'b1, 2);
    chk("conc_count", 32'(count), 32'd4);
    chk("conc_pc0", dec_pc[0], 32'h58);
    chk("conc_pc1", dec_pc[1], 32'h5C);
    repeat (2) idle(1'b1);

    // flush overrides enqueue and dequeue
    grp(32'h70, 1'b0, 2);
    grp(32'h78, 1'b0, 2);
    grp(32'h80, 1'b0, 2);
    chk("fl_count6", 32'(count), 32'd6);
    cyc(2'b11, 32'h88, 32'h8C, 32'h1, 32'h2, 1'b1, 1'b1, 2);
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_dec_valid", 32'(dec_valid), 32'd0);
    chk("fl_stall", 32'(fetch_stall), 32'd0);
    chk("fl_ovf_kept", 32'(overflow_err), 32'd1);
    idle(1'b0);
    chk("fl_still_empty", 32'(count), 32'd0);

    // reset mid-operation
    grp(32'h90, 1'b0, 2);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_ovf", 32'(overflow_err), 32'd0);

    // streaming across pointer wrap
    for (int g = 0; g < 10; g++) grp(32'(g * 8), 1'b1, 2);
    repeat (2) idle(1'b1);
    chk("wrap_count", 32'(count), 32'd0);
    chk("wrap_ovf", 32'(overflow_err), 32'd0);
    chk("wrap_all_seen", 32'(exp_q.size()), 32'd0);

    idle(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
